// File: rtl/button_conditioner.sv
// button_conditioner: per-bit 2-flop synchronizer, sample-tick saturating
// debouncer and edge detector for board push-buttons and switches.
// All bits share one free-running sample-tick counter.
// Optional feature macro: BUTTON_CONDITIONER_RELEASE_PULSE_EN
//   defined   -> out_release pulses one cycle after out_level falls
//   undefined -> out_release is tied to 0 (port kept, no extra flops)
module button_conditioner #(
  parameter int WIDTH          = 4,
  parameter int SAMPLE_CNT_MAX = 62500,
  parameter int PULSE_CNT_MAX  = 200
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out_level,
  output logic [WIDTH-1:0] out_pulse,
  output logic [WIDTH-1:0] out_release
);

  // A one-cycle sample period still needs a 1-bit counter to exist.
  localparam int TICK_W = (SAMPLE_CNT_MAX > 1) ? $clog2(SAMPLE_CNT_MAX) : 1;
  localparam int CNT_W  = $clog2(PULSE_CNT_MAX + 1);
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLE_CNT_MAX - 1);
  localparam logic [CNT_W-1:0]  CNT_SAT   = CNT_W'(PULSE_CNT_MAX);

  logic [WIDTH-1:0]            sync1_q;
  logic [WIDTH-1:0]            sync2_q;
  logic [TICK_W-1:0]           tick_cnt_q;
  logic [TICK_W-1:0]           tick_cnt_d;
  logic                        tick;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0][CNT_W-1:0] cnt_d;
  logic [WIDTH-1:0]            level_q;
  logic [WIDTH-1:0]            level_d;
  logic [WIDTH-1:0]            level_dly_q;
  logic [WIDTH-1:0]            pulse_q;
  logic [WIDTH-1:0]            pulse_d;

  // Two-stage synchronizer, nothing between the stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= in;
      sync2_q <= sync1_q;
    end
  end

  // Free-running sample counter; tick marks its last count.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
  end

  // Per-bit saturating sample counters, plus level and edge-detect next values.
  always_comb begin
    cnt_d   = cnt_q;
    level_d = '0;
    pulse_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (tick) begin
        if (!sync2_q[i])          cnt_d[i] = '0;
        else if (cnt_q[i] != CNT_SAT) cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end
      level_d[i] = (cnt_q[i] == CNT_SAT);
      pulse_d[i] = level_q[i] & ~level_dly_q[i];
    end
  end

  // Debounce state, level and pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tick_cnt_q  <= '0;
      cnt_q       <= '0;
      level_q     <= '0;
      level_dly_q <= '0;
      pulse_q     <= '0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      cnt_q       <= cnt_d;
      level_q     <= level_d;
      level_dly_q <= level_q;
      pulse_q     <= pulse_d;
    end
  end

  assign out_level = level_q;
  assign out_pulse = pulse_q;

`ifdef BUTTON_CONDITIONER_RELEASE_PULSE_EN
  logic [WIDTH-1:0] release_q;
  logic [WIDTH-1:0] release_d;

  // Falling-edge detect on the debounced level.
  always_comb begin
    release_d = ~level_q & level_dly_q;
  end

  // Release pulse register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) release_q <= '0;
    else     release_q <= release_d;
  end

  assign out_release = release_q;
`else
  assign out_release = '0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: randomized stimulus against an integer reference
// model of the conditioner (WIDTH=2, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3).
module tb_button_conditioner;

  localparam int W = 2;
  localparam int S = 4;
  localparam int P = 3;

  logic         clk;
  logic         rst;
  logic [W-1:0] in;
  logic [W-1:0] out_level;
  logic [W-1:0] out_pulse;
  logic [W-1:0] out_release;

  int tests;
  int errors;

  // Reference model state: input history, sample run lengths, level history.
  logic [W-1:0] in_q[$];
  logic [W-1:0] exp_q[$];
  int           run[W];
  int           n_edges;
  logic [W-1:0] exp_level;
  logic [W-1:0] exp_pulse;
  logic [W-1:0] exp_release;

  button_conditioner #(
    .WIDTH(W),
    .SAMPLE_CNT_MAX(S),
    .PULSE_CNT_MAX(P)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(in),
    .out_level(out_level),
    .out_pulse(out_pulse),
    .out_release(out_release)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    in_q.delete();
    exp_q.delete();
    exp_q.push_back('0);
    exp_q.push_back('0);
    for (int i = 0; i < W; i++) run[i] = 0;
    n_edges     = 0;
    exp_level   = '0;
    exp_pulse   = '0;
    exp_release = '0;
  endtask

  // One clock edge of the reference: the debouncer sees the input applied
  // two edges earlier; a sample is taken every S-th cycle since reset.
  task automatic model_edge(input logic [W-1:0] v);
    logic [W-1:0] seen;
    logic [W-1:0] prev1;
    logic [W-1:0] prev2;
    logic         sample;
    seen   = (in_q.size() >= 2) ? in_q[in_q.size()-2] : '0;
    sample = ((n_edges % S) == S - 1);
    prev1  = exp_q[1];
    prev2  = exp_q[0];
    for (int i = 0; i < W; i++) begin
      exp_level[i] = (run[i] >= P);
      if (sample) run[i] = seen[i] ? ((run[i] < P) ? run[i] + 1 : P) : 0;
    end
    exp_pulse = prev1 & ~prev2;
`ifdef BUTTON_CONDITIONER_RELEASE_PULSE_EN
    exp_release = ~prev1 & prev2;
`else
    exp_release = '0;
`endif
    exp_q.push_back(exp_level);
    void'(exp_q.pop_front());
    in_q.push_back(v);
    if (in_q.size() > 2) void'(in_q.pop_front());
    n_edges++;
  endtask

  // Driver: apply v for one cycle (called at a negedge), check on the next negedge.
  task automatic step(input logic [W-1:0] v);
    in = v;
    @(posedge clk);
    model_edge(v);
    @(negedge clk);
    check("out_level", out_level, exp_level);
    check("out_pulse", out_pulse, exp_pulse);
    check("out_release", out_release, exp_release);
  endtask

  // Assert rst mid-cycle, confirm immediate clearing, hold, release at a negedge.
  task automatic pulse_reset(input int hold);
    #2 rst = 1'b1;
    #1;
    check("rst_async_level", out_level, 0);
    check("rst_async_pulse", out_pulse, 0);
    check("rst_async_release", out_release, 0);
    @(negedge clk);
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      check("rst_hold_outputs", {out_level, out_pulse, out_release}, 0);
    end
    rst = 1'b0;
    model_reset();
  endtask

  task automatic idle_random();
    int k;
    k = $urandom_range(0, 7);
    for (int j = 0; j < k; j++) step('0);
  endtask

  initial begin
    int lat;
    int plat;
    int pulses;
    int rels;
    int max_cnt;
    logic [W-1:0] v;

    tests  = 0;
    errors = 0;
    rst    = 1'b1;
    in     = '0;
    model_reset();
    #1;
    check("reset_level", out_level, 0);
    check("reset_pulse", out_pulse, 0);
    check("reset_release", out_release, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Clean press on bit 0, bit 1 idle.
    idle_random();
    lat = 0; plat = 0; pulses = 0;
    for (int c = 1; c <= 24; c++) begin
      step(2'b01);
      if (out_level[0] && lat == 0) lat = c;
      if (out_pulse[0]) begin pulses++; if (plat == 0) plat = c; end
      check("press_bit1_quiet", {out_level[1], out_pulse[1]}, 0);
    end
    check("press_latency_in_window", (lat >= 12 && lat <= 15), 1);
    check("press_pulse_after_level", plat, lat + 1);
    check("press_pulse_count", pulses, 1);

    // Long hold: no second pulse, counter saturates at P.
    pulses = 0; max_cnt = 0;
    for (int c = 0; c < 200; c++) begin
      step(2'b01);
      if (out_pulse[0]) pulses++;
      if (int'(dut.cnt_q[0]) > max_cnt) max_cnt = int'(dut.cnt_q[0]);
      if (c % 50 == 49) check("hold_level", out_level[0], 1'b1);
    end
    check("hold_pulse_count", pulses, 0);
    check("hold_cnt_saturated", max_cnt, P);

    // Release.
    lat = 0; rels = 0;
    for (int c = 1; c <= 12; c++) begin
      step(2'b00);
      if (!out_level[0] && lat == 0) lat = c;
      if (out_release[0]) rels++;
    end
    check("release_latency_in_window", (lat >= 1 && lat <= 7), 1);
`ifdef BUTTON_CONDITIONER_RELEASE_PULSE_EN
    check("release_pulse_count", rels, 1);
`else
    check("release_pulse_count", rels, 0);
`endif

    // Bounce: toggle every 3 cycles for 40 cycles, then settle low.
    idle_random();
    pulses = 0; lat = 0;
    for (int c = 0; c < 52; c++) begin
      v = (c < 40 && ((c / 3) % 2 == 0)) ? 2'b01 : 2'b00;
      step(v);
      if (out_pulse[0]) pulses++;
      if (out_level[0]) lat++;
    end
    check("bounce_pulse_count", pulses, 0);
    check("bounce_level_cycles", lat, 0);

    // Simultaneous press on both bits.
    idle_random();
    plat = 0; pulses = 0;
    for (int c = 1; c <= 24; c++) begin
      step(2'b11);
      if (out_pulse != 0) begin
        pulses++;
        check("simul_pulse_both", out_pulse, 2'b11);
      end
    end
    check("simul_pulse_cycles", pulses, 1);

    // Reset while both held: pulse must come only after re-accumulation.
    pulse_reset($urandom_range(1, 4));
    lat = 0; plat = 0;
    for (int c = 1; c <= 24; c++) begin
      step(2'b11);
      if (out_level == 2'b11 && lat == 0) lat = c;
      if (out_pulse != 0 && plat == 0) plat = c;
    end
    check("post_reset_level_window", (lat >= 12 && lat <= 15), 1);
    check("post_reset_pulse_after_level", plat, lat + 1);

    // Random segments on both bits.
    for (int seg = 0; seg < 30; seg++) begin
      v = W'($urandom_range(0, 3));
      for (int k = $urandom_range(1, 24); k > 0; k--) step(v);
      if (seg == 15) pulse_reset($urandom_range(1, 3));
    end
    for (int c = 0; c < 8; c++) step('0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

  // Watchdog in case the stimulus ever stalls.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, errors + 1);
    $finish;
  end

endmodule
